bandwidth_regulator: RTL and testbench
======================================

// Module: bandwidth_regulator
// PURPOSE
//  Parametrised per-queue memory-bandwidth regulator: N request queues, each with a transaction budget
//  per replenishment period. Picks the next queue to serve with rotating-priority round-robin over
//  budget-eligible, non-empty queues, and issues a registered valid/ready grant to the memory port.
//  Optional work-conserving mode lends idle bandwidth to over-budget queues. Sits between the per-core
//  request queues and the downstream EDF/memory scheduler.
// PARAMETERS
//  NUMBER_OF_QUEUES  4   queues regulated; >=2
//  REGISTER_SIZE     16  width of budget, period and counters
//  WORK_CONSERVING   0   1 = grant over-budget queues when no in-budget queue is pending
// PORTS
//  clock         in   1                  rising-edge clock
//  reset         in   1                  asynchronous, active-low reset (0 = in reset)
//  enable        in   1                  0 = issue no new grants; a grant already held still completes
//  budgets       in   N x REGISTER_SIZE  transactions allowed per period, per queue
//  period        in   REGISTER_SIZE      replenishment period in cycles; 0 is treated as 1
//  empty         in   N                  1 = queue i has no pending request
//  ready         in   1                  downstream accepts the current grant
//  valid         out  1                  grant pending
//  selection     out  clog2(N)           granted queue id; stable while valid & !ready
//  best_effort   out  1                  grant issued under the work-conserving rule, not budget
//  exhausted     out  N                  consumed[i] >= budgets[i]
//  period_start  out  1                  one-cycle pulse on the first cycle of each period
// BEHAVIOUR
//  Reset: valid=0, selection=0, best_effort=0, period_start=0, pointer=0, period counter=0, consumed[*]=0.
//    exhausted = (0 >= budgets), so queues with a 0 budget read as exhausted.
//  Period counter: counts 0..max(period,1)-1.
//    - On the last count, all consumed[*] clear on the next edge, the counter wraps to 0 and
//      period_start=1 for that cycle.
//    - A period change takes effect at the next wrap, or immediately if counter >= the new period-1.
//  Eligibility (combinational): elig[i] = !empty[i] & (consumed[i] < budgets[i]).
//    Budgets are compared live, so a mid-period change applies at once.
//  Arbitration: first elig[i] scanning pointer, pointer+1, ... mod N.
//    - If no queue is eligible, WORK_CONSERVING=1 and some queue is non-empty: first non-empty queue
//      from the pointer, with best_effort=1.
//  Grant register: when (!valid | ready) & enable & a winner exists, next cycle valid=1 and selection
//    and best_effort are loaded. Latency is 1 cycle from request/eligibility to valid.
//  Hold: while valid & !ready, selection and best_effort are frozen. empty, budget and replenish
//    changes do not withdraw the grant.
//  Handshake (valid & ready):
//    - Budget grant: consumed[sel] +1, saturating at all-ones.
//    - Best-effort grant: consumed is unchanged.
//    - pointer <= sel+1 mod N.
//    - valid may re-assert back-to-back if a winner exists, giving 1 grant/cycle throughput.
//  Simultaneous handshake and replenish: the replenish wins and consumed[sel] ends at 0.
//    The transaction is charged to the old period.
//  enable=0 with valid=1: the grant holds until ready, then valid drops.
//  Reset asserted mid-grant: all state returns to reset values immediately (asynchronous); no
//    completion.
// STRUCTURE
//  Package bandwidth_regulator_pkg: queue_id_t width function (clog2 with a minimum of 1),
//    grant_kind_e {BUDGET, BEST_EFFORT}, PERIOD_MIN = 1.
//  Sub-module rr_picker: combinational rotating-priority find-first.
//    Inputs: request vector, pointer. Outputs: found, index.
//    Instantiated twice: eligible set and non-empty set.
//  Top level holds the period counter, consumed[] bank, pointer and grant register.
// TESTING
//  1. N=4, budgets={2,2,2,2}, period=20, all non-empty, ready=1:
//     grants 0,1,2,3,0,1,2,3, then valid=0 until period_start; all exhausted=1 before the wrap.
//  2. Back-pressure: ready=0 for 5 cycles after valid:
//     selection is stable and consumed is unchanged; the ready pulse increments exactly one counter.
//  3. budgets={0,3,0,0}, WORK_CONSERVING=1, only q1 and q2 non-empty:
//     q1 is granted 3x with best_effort=0, then q2 is granted with best_effort=1 and consumed[2]=0.
//  4. Handshake on the last period cycle: consumed[sel] is 0 after the edge and period_start=1.
//  5. period=0:
//     behaves as period=1, with replenish every cycle and period_start stuck at 1 after the first cycle.
//  6. Assert reset while valid=1:
//     valid=0 asynchronously; after release, the first grant goes to q0 (pointer=0).

Source files
------------

// File: rtl/bandwidth_regulator_pkg.sv
// Shared definitions for the bandwidth regulator.
//   queue_id_width : width of a queue index (clog2, never below 1)
//   grant_kind_e   : why a grant was issued (budget or work-conserving loan)
//   PERIOD_MIN     : smallest usable replenishment period
package bandwidth_regulator_pkg;

    localparam int PERIOD_MIN = 1;

    typedef enum logic {
        BUDGET      = 1'b0,
        BEST_EFFORT = 1'b1
    } grant_kind_e;

    function automatic int queue_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bandwidth_regulator_rr_picker.sv
// Rotating-priority find-first.
//   request : one bit per queue, 1 = candidate
//   pointer : queue with highest priority this cycle (must be < N)
//   found   : at least one request bit is set
//   index   : first set request at or after pointer, wrapping modulo N
module rr_picker
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] pointer,
    output logic          found,
    output logic [IW-1:0] index
);

    // cand[k] is the queue examined at priority rank k (rank 0 = pointer).
    logic [IW-1:0] cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum       = {1'b0, pointer} + (IW+1)'(gi);
        assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end

    // Scan from the lowest priority upwards so the highest-priority hit is
    // the one left standing.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (request[cand[k]]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/bandwidth_regulator.sv
// Per-queue memory-bandwidth regulator.
//   clock        : rising-edge clock
//   reset        : asynchronous, active-low
//   enable       : 0 = no new grants (a held grant still completes)
//   budgets      : per-queue transactions allowed per period
//   period       : replenishment period in cycles (0 behaves as 1)
//   empty        : per-queue, 1 = nothing pending
//   ready        : downstream accepts the current grant
//   valid        : grant pending
//   selection    : granted queue id, frozen while valid & !ready
//   best_effort  : grant issued as a work-conserving loan
//   exhausted    : per-queue consumed >= budget
//   period_start : one-cycle pulse on the first cycle of each period
module bandwidth_regulator
    import bandwidth_regulator_pkg::*;
#(
    parameter int  NUMBER_OF_QUEUES = 4,
    parameter int  REGISTER_SIZE    = 16,
    parameter int  WORK_CONSERVING  = 0,
    localparam int QW               = queue_id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             enable,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   budgets,
    input  logic [REGISTER_SIZE-1:0]                         period,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
    input  logic                                             ready,
    output logic                                             valid,
    output logic [QW-1:0]                                    selection,
    output logic                                             best_effort,
    output logic [NUMBER_OF_QUEUES-1:0]                      exhausted,
    output logic                                             period_start
);

    localparam int N  = NUMBER_OF_QUEUES;
    localparam int RS = REGISTER_SIZE;
    localparam bit WC = (WORK_CONSERVING != 0);

    logic [RS-1:0]  count_reg;
    logic           period_start_reg;
    logic [RS-1:0]  consumed_reg  [N];
    logic [RS-1:0]  consumed_next [N];
    logic [QW-1:0]  pointer_reg;
    logic [QW-1:0]  pointer_next;
    logic           valid_reg;
    logic [QW-1:0]  selection_reg;
    grant_kind_e    kind_reg;

    logic [RS-1:0]  period_eff;
    logic           wrap;
    logic           handshake;
    logic           charge;
    logic [N-1:0]   eligible;
    logic [N-1:0]   busy;
    logic           elig_found;
    logic [QW-1:0]  elig_index;
    logic           busy_found;
    logic [QW-1:0]  busy_index;
    logic           winner;
    logic           load;

    // ---------------- period counter ----------------
    assign period_eff = (period < RS'(PERIOD_MIN)) ? RS'(PERIOD_MIN) : period;
    // ">=" rather than "==" so a period shrunk below the current count
    // wraps on the very next edge instead of running to overflow.
    assign wrap       = (count_reg >= period_eff - RS'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg        <= '0;
            period_start_reg <= 1'b0;
        end else begin
            count_reg        <= wrap ? '0 : count_reg + RS'(1);
            period_start_reg <= wrap;
        end
    end

    // ---------------- consumed bank ----------------
    assign handshake = valid_reg & ready;
    assign charge    = handshake & (kind_reg == BUDGET);

    for (genvar gi = 0; gi < N; gi++) begin : g_queue
        // Replenish overrides the charge: the transaction belongs to the
        // period that is ending.
        always_comb begin
            consumed_next[gi] = consumed_reg[gi];
            if (wrap) begin
                consumed_next[gi] = '0;
            end else if (charge && (selection_reg == QW'(gi)) && (consumed_reg[gi] != '1)) begin
                consumed_next[gi] = consumed_reg[gi] + RS'(1);
            end
        end

        // Arbitration looks at the post-edge consumed value so a grant that
        // completes this cycle is already counted against the next pick.
        assign eligible[gi]  = !empty[gi] && (consumed_next[gi] < budgets[gi]);
        assign busy[gi]      = !empty[gi];
        assign exhausted[gi] = (consumed_reg[gi] >= budgets[gi]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                consumed_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                consumed_reg[i] <= consumed_next[i];
            end
        end
    end

    // ---------------- pointer ----------------
    // Likewise the rotation moves past a completing grant before the next
    // pick, which is what gives fair back-to-back grants.
    always_comb begin
        pointer_next = pointer_reg;
        if (handshake) begin
            pointer_next = (selection_reg == QW'(N - 1)) ? '0 : selection_reg + QW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pointer_reg <= '0;
        end else begin
            pointer_reg <= pointer_next;
        end
    end

    // ---------------- arbitration ----------------
    rr_picker #(.N(N), .IW(QW)) u_pick_eligible (
        .request (eligible),
        .pointer (pointer_next),
        .found   (elig_found),
        .index   (elig_index)
    );

    rr_picker #(.N(N), .IW(QW)) u_pick_busy (
        .request (busy),
        .pointer (pointer_next),
        .found   (busy_found),
        .index   (busy_index)
    );

    assign winner = elig_found | (WC & busy_found);
    assign load   = (!valid_reg | ready) & enable & winner;

    // ---------------- grant register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg     <= 1'b0;
            selection_reg <= '0;
            kind_reg      <= BUDGET;
        end else if (load) begin
            valid_reg     <= 1'b1;
            selection_reg <= elig_found ? elig_index : busy_index;
            kind_reg      <= elig_found ? BUDGET : BEST_EFFORT;
        end else if (handshake) begin
            valid_reg     <= 1'b0;
        end
    end

    assign valid        = valid_reg;
    assign selection    = selection_reg;
    assign best_effort  = (kind_reg == BEST_EFFORT);
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_bandwidth_regulator.sv
module tb_bandwidth_regulator;

    typedef struct packed {
        logic [1:0] sel;
        logic       be;
    } grant_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [3:0][15:0] budgets;
    logic [15:0]      period;
    logic [3:0]       empty;
    logic             ready;

    logic             valid, valid_wc;
    logic [1:0]       selection, selection_wc;
    logic             best_effort, best_effort_wc;
    logic [3:0]       exhausted, exhausted_wc;
    logic             period_start, period_start_wc;

    grant_t sb [$];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bandwidth_regulator #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(16), .WORK_CONSERVING(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .budgets(budgets), .period(period),
        .empty(empty), .ready(ready), .valid(valid), .selection(selection),
        .best_effort(best_effort), .exhausted(exhausted), .period_start(period_start)
    );

    bandwidth_regulator #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(16), .WORK_CONSERVING(1)) dut_wc (
        .clock(clock), .reset(reset), .enable(enable), .budgets(budgets), .period(period),
        .empty(empty), .ready(ready), .valid(valid_wc), .selection(selection_wc),
        .best_effort(best_effort_wc), .exhausted(exhausted_wc), .period_start(period_start_wc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] s, input logic b);
        grant_t e;
        e.sel = s;
        e.be  = b;
        sb.push_back(e);
    endtask

    // Called at a negedge where valid & ready holds: the handshake happens
    // on the coming posedge.
    task automatic take_grant(input bit wc);
        grant_t     e;
        logic [1:0] s;
        logic       b;
        s = wc ? selection_wc : selection;
        b = wc ? best_effort_wc : best_effort;
        $display("grant q%0d best_effort=%0d (wc_dut=%0d)", s, b, wc);
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("grant_sel", 32'(s), 32'(e.sel));
            check("grant_kind", 32'(b), 32'(e.be));
        end
    endtask

    task automatic do_reset(input logic [3:0] exh_exp);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_selection", 32'(selection), 32'd0);
        check("rst_best_effort", 32'(best_effort), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_exhausted", 32'(exhausted), 32'(exh_exp));
        reset = 1'b1;
    endtask

    initial begin
        bit         seen_ps;
        logic [3:0] last_exh;
        logic       last_valid;

        reset   = 1'b0;
        enable  = 1'b1;
        budgets = {16'd2, 16'd2, 16'd2, 16'd2};
        period  = 16'd20;
        empty   = 4'b0000;
        ready   = 1'b1;

        // ---- 1: round robin until all budgets spent, then idle to wrap
        do_reset(4'h0);
        for (int i = 0; i < 8; i++) push_exp(2'(i % 4), 1'b0);
        seen_ps    = 1'b0;
        last_exh   = '0;
        last_valid = 1'b1;
        for (int c = 0; c < 40 && !seen_ps; c++) begin
            @(negedge clock);
            if (period_start) begin
                seen_ps = 1'b1;
            end else begin
                last_exh   = exhausted;
                last_valid = valid;
                if (valid && ready) take_grant(1'b0);
            end
        end
        check("t1_period_start_seen", 32'(seen_ps), 32'd1);
        check("t1_exhausted_before_wrap", 32'(last_exh), 32'hF);
        check("t1_idle_before_wrap", 32'(last_valid), 32'd0);
        check("t1_all_grants_seen", 32'(sb.size()), 32'd0);
        check("t1_exhausted_after_wrap", 32'(exhausted), 32'h0);

        // ---- 2: back-pressure, then enable=0 with a held grant
        budgets = {16'd1, 16'd1, 16'd1, 16'd1};
        ready   = 1'b0;
        do_reset(4'h0);
        @(negedge clock);
        check("t2_valid", 32'(valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("t2_hold_sel", 32'(selection), 32'd0);
            check("t2_hold_valid", 32'(valid), 32'd1);
            check("t2_hold_consumed", 32'(exhausted), 32'h0);
        end
        push_exp(2'd0, 1'b0);
        ready = 1'b1;
        take_grant(1'b0);
        @(negedge clock);
        ready = 1'b0;
        check("t2_one_counter", 32'(exhausted), 32'h1);
        check("t2_next_valid", 32'(valid), 32'd1);
        check("t2_next_sel", 32'(selection), 32'd1);
        push_exp(2'd1, 1'b0);
        enable = 1'b0;
        ready  = 1'b1;
        take_grant(1'b0);
        @(negedge clock);
        check("t2_disabled_drop", 32'(valid), 32'd0);
        check("t2_disabled_charge", 32'(exhausted), 32'h3);
        enable = 1'b1;
        ready  = 1'b0;

        // ---- 3: work-conserving loan to an over-budget queue
        budgets = {16'd0, 16'd0, 16'd3, 16'd0};
        empty   = 4'b1001;
        ready   = 1'b1;
        do_reset(4'b1101);
        push_exp(2'd1, 1'b0);
        push_exp(2'd1, 1'b0);
        push_exp(2'd1, 1'b0);
        push_exp(2'd2, 1'b1);
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(negedge clock);
            if (valid_wc && ready) take_grant(1'b1);
        end
        check("t3_all_grants_seen", 32'(sb.size()), 32'd0);
        @(negedge clock);
        ready      = 1'b0;
        budgets[2] = 16'd1;
        @(negedge clock);
        check("t3_exhausted", 32'(exhausted_wc), 32'b1011);
        check("t3_held_valid", 32'(valid_wc), 32'd1);
        check("t3_held_sel", 32'(selection_wc), 32'd1);
        check("t3_held_be", 32'(best_effort_wc), 32'd1);

        // ---- 4: handshake on the last cycle of a period
        budgets = {16'd1, 16'd1, 16'd1, 16'd1};
        period  = 16'd4;
        empty   = 4'b1110;
        ready   = 1'b0;
        do_reset(4'h0);
        push_exp(2'd0, 1'b0);
        repeat (3) @(negedge clock);
        check("t4_no_pulse_yet", 32'(period_start), 32'd0);
        check("t4_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        take_grant(1'b0);
        @(negedge clock);
        ready = 1'b0;
        check("t4_period_start", 32'(period_start), 32'd1);
        check("t4_consumed_cleared", 32'(exhausted), 32'h0);

        // ---- 5: period 0 behaves as 1
        period = 16'd0;
        empty  = 4'b0000;
        ready  = 1'b1;
        do_reset(4'h0);
        push_exp(2'd0, 1'b0);
        push_exp(2'd1, 1'b0);
        push_exp(2'd2, 1'b0);
        push_exp(2'd3, 1'b0);
        push_exp(2'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("t5_period_start", 32'(period_start), 32'd1);
            check("t5_valid", 32'(valid), 32'd1);
            if (valid && ready) take_grant(1'b0);
        end
        check("t5_all_grants_seen", 32'(sb.size()), 32'd0);

        // ---- 6: asynchronous reset while a grant is held
        period = 16'd20;
        ready  = 1'b0;
        do_reset(4'h0);
        @(negedge clock);
        check("t6_valid", 32'(valid), 32'd1);
        push_exp(2'd0, 1'b0);
        ready = 1'b1;
        take_grant(1'b0);
        @(negedge clock);
        ready = 1'b0;
        check("t6_sel_before_reset", 32'(selection), 32'd1);
        check("t6_exh_before_reset", 32'(exhausted), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_sel", 32'(selection), 32'd0);
        check("t6_async_exh", 32'(exhausted), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_regrant_valid", 32'(valid), 32'd1);
        check("t6_regrant_sel", 32'(selection), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
